glip_downscale_n: RTL and testbench

//  Downscales a FIFO-style valid/ready stream by an integer ratio RATIO:1.

---
 rtl/glip_scale_pkg.sv | 14 +
 rtl/glip_downscale_n.sv | 77 +++++++
 tb/tb_glip_downscale_n.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glip_scale_pkg.sv
// Shared helpers for the GLIP stream width converters (downscale now, upscale next).
// Holds the chunk-count normalisation rule and the input word width derivation.
package glip_scale_pkg;

  // A count of 0, or one larger than the ratio, means "the whole word".
  function automatic int glip_eff_chunks(input int cnt, input int ratio);
    return ((cnt == 0) || (cnt > ratio)) ? ratio : cnt;
  endfunction

  function automatic int glip_in_size(input int out_size, input int ratio);
    return out_size * ratio;
  endfunction

endpackage

// File: rtl/glip_downscale_n.sv
// RATIO:1 valid/ready downscaler: each wide word leaves as up to RATIO narrow chunks, MSB first.
// Optional out_last port is enabled by defining GLIP_DOWNSCALE_LAST_EN.
module glip_downscale_n
  import glip_scale_pkg::*;
#(
  parameter int OUT_SIZE = 16,
  parameter int RATIO    = 2,
  parameter int CNT_W    = $clog2(RATIO + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OUT_SIZE*RATIO-1:0] in_data,
  input  logic [CNT_W-1:0]          in_chunks,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [OUT_SIZE-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef GLIP_DOWNSCALE_LAST_EN
  ,
  output logic                      out_last
`endif
);

  localparam int IN_SIZE = glip_in_size(OUT_SIZE, RATIO);

  if ((RATIO < 1) || (OUT_SIZE < 1)) begin : g_bad
    $fatal(1, "glip_downscale_n: RATIO and OUT_SIZE must both be >= 1");
  end else if (RATIO == 1) begin : g_wire
    logic w_unused;

    assign w_unused  = ^{clk, rst, in_chunks};
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
`ifdef GLIP_DOWNSCALE_LAST_EN
    assign out_last  = in_valid;
`endif
  end else begin : g_conv
    localparam int BUF_W = IN_SIZE - OUT_SIZE;

    logic [CNT_W-1:0] r_rem;
    logic [BUF_W-1:0] r_buf;
    logic             w_busy;
    logic [CNT_W-1:0] w_n;

    assign w_n    = CNT_W'(glip_eff_chunks(int'(in_chunks), RATIO));
    assign w_busy = (r_rem != '0);

    // Idle is a zero-latency passthrough of chunk 0; busy drains the buffer.
    assign in_ready  = w_busy ? 1'b0 : out_ready;
    assign out_valid = w_busy ? 1'b1 : in_valid;
    assign out_data  = w_busy ? r_buf[BUF_W-1 -: OUT_SIZE]
                              : in_data[IN_SIZE-1 -: OUT_SIZE];

`ifdef GLIP_DOWNSCALE_LAST_EN
    assign out_last = out_valid &
                      (w_busy ? (r_rem == CNT_W'(1)) : (w_n == CNT_W'(1)));
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rem <= '0;
        r_buf <= '0;
      end else if (!w_busy) begin
        if (in_valid && out_ready) begin
          r_rem <= w_n - CNT_W'(1);
          r_buf <= in_data[BUF_W-1:0];
        end
      end else if (out_ready) begin
        r_rem <= r_rem - CNT_W'(1);
        r_buf <= r_buf << OUT_SIZE;
      end
    end
  end

endmodule

// File: tb/tb_glip_downscale_n.sv
// Self-checking bench for glip_downscale_n: scoreboard of expected chunks plus directed literal cases.
// Works with and without GLIP_DOWNSCALE_LAST_EN defined.
module tb_glip_downscale_n;

   typedef struct {
      logic [7:0] d;
      logic       last;
   } chunk_t;

   logic        clk;
   logic        rst;
   logic [31:0] inData;
   logic [2:0]  inChunks;
   logic        inValid;
   logic        inReady;
   logic [7:0]  outData;
   logic        outValid;
   logic        outReady;
`ifdef GLIP_DOWNSCALE_LAST_EN
   logic        outLast;
   logic        w1OutLast;
`endif

   logic [15:0] w1InData;
   logic [0:0]  w1Chunks;
   logic        w1InValid;
   logic        w1InReady;
   logic [15:0] w1OutData;
   logic        w1OutValid;
   logic        w1OutReady;

   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   bit          checkEn = 0;
   bit          readyMode = 0;
   int          lowReadyCnt = 0;

   chunk_t      expQ[$];
   logic [7:0]  obsData[$];
   logic        obsLast[$];
   int          obsCyc[$];
   logic [7:0]  expLog[$];

   int          pending;
   logic        expRdy;
   logic        expVld;
   chunk_t      head;
   bit          prevStall = 0;
   logic [7:0]  prevData = '0;

   glip_downscale_n #(.OUT_SIZE(8), .RATIO(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (inData),
      .in_chunks (inChunks),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .out_data  (outData),
      .out_valid (outValid),
      .out_ready (outReady)
`ifdef GLIP_DOWNSCALE_LAST_EN
      ,
      .out_last  (outLast)
`endif
   );

   glip_downscale_n #(.OUT_SIZE(16), .RATIO(1)) dutWire (
      .clk       (clk),
      .rst       (rst),
      .in_data   (w1InData),
      .in_chunks (w1Chunks),
      .in_valid  (w1InValid),
      .in_ready  (w1InReady),
      .out_data  (w1OutData),
      .out_valid (w1OutValid),
      .out_ready (w1OutReady)
`ifdef GLIP_DOWNSCALE_LAST_EN
      ,
      .out_last  (w1OutLast)
`endif
   );

   // Free-running clock and cycle counter used to prove back-to-back chunks.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Random backpressure, applied just after each rising edge when enabled.
   always @(posedge clk) begin
      if (readyMode) begin
         #1;
         outReady = 1'($urandom_range(0, 1));
      end
   end

   // Hard stop in case something wedges the whole run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int effN(input int c);
      return ((c == 0) || (c > 4)) ? 4 : c;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // The model: a word with n effective chunks becomes n bytes, top byte first.
   task automatic pushWord(input logic [31:0] w, input logic [2:0] c);
      int n;
      chunk_t ch;
      n = effN(int'(c));
      for (int i = 0; i < n; i++) begin
         ch.d    = 8'((w >> (8 * (3 - i))) & 32'hFF);
         ch.last = (i == n - 1);
         expQ.push_back(ch);
      end
   endtask

   // Compare process: predicted handshake signals, head chunk and stall stability every cycle.
   always @(negedge clk) begin
      if (checkEn && !rst) begin
         pending = expQ.size();
         expRdy  = (pending == 0) && outReady;
         expVld  = (pending != 0) || inValid;
         checkOutput("in_ready", 32'(inReady), 32'(expRdy));
         checkOutput("out_valid", 32'(outValid), 32'(expVld));
         if (!inReady) lowReadyCnt++;
         if (inValid && expRdy) pushWord(inData, inChunks);
         if (expVld) begin
            if (expQ.size() != 0) begin
               head = expQ[0];
            end else begin
               head.d    = inData[31:24];
               head.last = (effN(int'(inChunks)) == 1);
            end
            checkOutput("out_data", 32'(outData), 32'(head.d));
`ifdef GLIP_DOWNSCALE_LAST_EN
            checkOutput("out_last", 32'(outLast), 32'(head.last));
`endif
            if (outReady && (expQ.size() != 0)) void'(expQ.pop_front());
         end
         if (prevStall) begin
            checkOutput("stall_valid", 32'(outValid), 32'd1);
            checkOutput("stall_data", 32'(outData), 32'(prevData));
         end
         prevStall = outValid && !outReady;
         prevData  = outData;
         if (outValid && outReady) begin
            obsData.push_back(outData);
            obsCyc.push_back(cycle);
`ifdef GLIP_DOWNSCALE_LAST_EN
            obsLast.push_back(outLast);
`endif
         end
      end else begin
         prevStall = 1'b0;
      end
   end

   // Present one word and hold it until it is accepted.
   task automatic applyStimulus(input logic [31:0] d, input logic [2:0] c);
      int waitCnt;
      bit done;
      waitCnt = 0;
      done    = 0;
      inValid  = 1'b1;
      inData   = d;
      inChunks = c;
      while (!done) begin
         @(negedge clk);
         if (inReady) begin
            done = 1;
         end else begin
            waitCnt++;
            if (waitCnt > 500) begin
               checks++;
               errors++;
               $display("[TB] FAIL accept_timeout: got no in_ready after %0d cycles expected acceptance", waitCnt);
               done = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      inValid  = 1'b0;
      inData   = $urandom;
      inChunks = 3'($urandom_range(0, 7));
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (((expQ.size() != 0) || inValid) && (n < 5000)) begin
         @(posedge clk);
         n++;
      end
      checkOutput("drain_timeout", 32'(n < 5000), 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic clearLog();
      obsData.delete();
      obsCyc.delete();
      obsLast.delete();
   endtask

   task automatic checkLog(input string name, input bit consec);
      checkOutput({name, "_count"}, 32'(obsData.size()), 32'(expLog.size()));
      for (int i = 0; (i < expLog.size()) && (i < obsData.size()); i++) begin
         checkOutput($sformatf("%s_data%0d", name, i), 32'(obsData[i]), 32'(expLog[i]));
         if (consec && (i > 0))
            checkOutput($sformatf("%s_gap%0d", name, i), 32'(obsCyc[i] - obsCyc[i-1]), 32'd1);
      end
   endtask

`ifdef GLIP_DOWNSCALE_LAST_EN
   task automatic checkLast(input string name, input logic [7:0] bits);
      for (int i = 0; (i < expLog.size()) && (i < obsLast.size()); i++)
         checkOutput($sformatf("%s_last%0d", name, i), 32'(obsLast[i]), 32'(bits[i]));
   endtask
`endif

   initial begin
      rst        = 1'b1;
      inValid    = 1'b1;
      inData     = 32'hAABBCCDD;
      inChunks   = 3'd0;
      outReady   = 1'b0;
      w1InData   = '0;
      w1Chunks   = '0;
      w1InValid  = 1'b0;
      w1OutReady = 1'b0;
      #2;
      // During reset the block is an idle passthrough.
      checkOutput("rst_out_valid", 32'(outValid), 32'd1);
      checkOutput("rst_in_ready", 32'(inReady), 32'd0);
      checkOutput("rst_out_data", 32'(outData), 32'hAA);
      outReady = 1'b1;
      #1;
      checkOutput("rst_in_ready_follow", 32'(inReady), 32'd1);
      inValid = 1'b0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      checkEn = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] full word, in_chunks=0");
      clearLog();
      lowReadyCnt = 0;
      applyStimulus(32'hAABBCCDD, 3'd0);
      waitDrain();
      expLog = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
      checkLog("t1", 1'b1);
      checkOutput("t1_in_ready_low", 32'(lowReadyCnt), 32'd3);
`ifdef GLIP_DOWNSCALE_LAST_EN
      checkLast("t1", 8'b0000_1000);
`endif

      $display("[TB] partial words back to back");
      clearLog();
      applyStimulus(32'h11223344, 3'd2);
      applyStimulus(32'h55667788, 3'd1);
      waitDrain();
      expLog = {8'h11, 8'h22, 8'h55};
      checkLog("t2", 1'b1);
`ifdef GLIP_DOWNSCALE_LAST_EN
      checkLast("t2", 8'b0000_0110);
`endif

      $display("[TB] overflow count treated as full word");
      clearLog();
      applyStimulus(32'h12345678, 3'd7);
      waitDrain();
      expLog = {8'h12, 8'h34, 8'h56, 8'h78};
      checkLog("t6", 1'b1);
`ifdef GLIP_DOWNSCALE_LAST_EN
      checkLast("t6", 8'b0000_1000);
`endif

      $display("[TB] asynchronous reset mid-word");
      clearLog();
      applyStimulus(32'hAABBCCDD, 3'd0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      expQ.delete();
      #1;
      checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
      checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
      rst = 1'b0;
      applyStimulus(32'h01020304, 3'd4);
      waitDrain();
      expLog = {8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
      checkLog("t4", 1'b0);
`ifdef GLIP_DOWNSCALE_LAST_EN
      checkLast("t4", 8'b0010_0000);
`endif

      $display("[TB] random words with random backpressure");
      readyMode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         applyStimulus($urandom, 3'($urandom_range(0, 7)));
         repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
         end
      end
      waitDrain();
      readyMode = 1'b0;
      @(posedge clk);
      #2;
      outReady = 1'b1;
      checkOutput("t3_queue_empty", 32'(expQ.size()), 32'd0);

      $display("[TB] RATIO=1 pure wires");
      for (int i = 0; i < 12; i++) begin
         w1InData   = 16'($urandom);
         w1Chunks   = 1'(i);
         w1InValid  = 1'($urandom_range(0, 1));
         w1OutReady = 1'($urandom_range(0, 1));
         #1;
         checkOutput("r1_out_data", 32'(w1OutData), 32'(w1InData));
         checkOutput("r1_in_ready", 32'(w1InReady), 32'(w1OutReady));
         checkOutput("r1_out_valid", 32'(w1OutValid), 32'(w1InValid));
`ifdef GLIP_DOWNSCALE_LAST_EN
         checkOutput("r1_out_last", 32'(w1OutLast), 32'(w1InValid));
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
